fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Decoupled, parametrised fetch front end for the superscalar core.
- Runs ahead of decode:
  - issues pipelined word requests to the instruction memory port, with up to MAX_OUTSTANDING requests in flight;
  - buffers returned instructions and their PCs in a circular queue;
  - presents up to ISSUE_WIDTH in-order instructions per cycle to decode.
- Redirects (branch/JAL/JALR resolved downstream) flush the queue and discard stale in-flight responses.

Parameters:
- CORE, 0: core index, used in report output.
- DATA_WIDTH, 32: instruction width.
- ADDRESS_BITS, 20: byte-address width.
- QUEUE_DEPTH, 8: queue entries; power of 2, at least 2.
- ISSUE_WIDTH, 2: decode lanes; 1 to QUEUE_DEPTH.
- MAX_OUTSTANDING, 4: maximum in-flight memory requests; power of 2.

Ports:
- clock, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- start, input, 1: begin fetching at program_address.
- program_address, input, ADDRESS_BITS: boot PC (byte address).
- redirect, input, 1: control-flow redirect from execute.
- redirect_target, input, ADDRESS_BITS: new PC (byte address).
- mem_req_valid, output, 1: fetch request valid.
- mem_req_ready, input, 1: memory accepts request.
- mem_req_addr, output, ADDRESS_BITS: word address (PC >> 2).
- mem_rsp_valid, input, 1: response valid; responses return in request order.
- mem_rsp_data, input, DATA_WIDTH: instruction.
- out_valid, output, ISSUE_WIDTH: lane i holds an instruction.
- out_inst, output, ISSUE_WIDTH*DATA_WIDTH: lane i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_pc, output, ISSUE_WIDTH*ADDRESS_BITS: byte PC per lane.
- out_ready, input, 1: decode consumes all valid lanes this cycle.
- report, input, 1: print state via $display.

Behaviour:
- States IDLE and RUN.
- Reset:
  - state = IDLE; all pointers, queue count, inflight and drop_count = 0; fetch_pc = 0.
  - All outputs 0: mem_req_valid = 0, out_valid = 0, mem_req_addr = 0.
  - Reset mid-operation discards everything; responses arriving in the reset cycle are ignored.
- IDLE:
  - No requests issued.
  - start: fetch_pc = program_address with bits [1:0] cleared; go to RUN.
- RUN:
  - Request condition: mem_req_valid = 1 when (count + inflight) < QUEUE_DEPTH and inflight < MAX_OUTSTANDING and no redirect/start this cycle. The credit rule guarantees every response has a queue slot.
  - mem_req_addr = fetch_pc >> 2.
  - On mem_req_valid && mem_req_ready: fetch_pc += 4, wrapping modulo 2^ADDRESS_BITS; inflight increments.
  - Each mem_rsp_valid decrements inflight:
    - drop_count > 0: decrement drop_count and discard the response.
    - otherwise: enqueue {mem_rsp_data, rsp_pc}. rsp_pc is a separate counter advanced by 4 per accepted (non-dropped) response and reloaded on redirect.
  - Decode lanes:
    - Lane i valid iff count > i; lane 0 is the oldest.
    - out_* are driven combinationally from queue storage.
    - On out_ready: dequeue popcount(out_valid) entries.
  - Enqueue and dequeue in the same cycle are both applied; count updates by the net amount.
  - Response latency to decode: an instruction enqueued in cycle N is visible on out_valid in cycle N+1.
- Redirect, or start while in RUN (start acts as a redirect to program_address):
  - Queue flushed: count = 0 and pointers reset. Dequeue and enqueue in that cycle are suppressed.
  - fetch_pc and rsp_pc = target with [1:0] cleared.
  - drop_count = inflight + (request accepted this cycle ? 1 : 0) - (response this cycle ? 1 : 0). The request term is always 0 because requests are blocked that cycle.
  - First new request goes out the following cycle.
  - Redirect while drop_count > 0: drop_count recomputed by the same formula.
- Priority: reset > start > redirect > normal.
- Boundary cases:
  - Queue full: no request is issued, and overflow cannot occur.
  - Empty: out_valid = 0, and out_ready is ignored.
  - mem_req_ready low: request and address held stable, fetch_pc unchanged.
  - A response arriving with inflight = 0 is a protocol error; it is ignored, and in simulation an $error is raised.
- Report: print cycle count, state, fetch_pc, count, inflight, drop_count, lane valids/PCs.

Decomposition:
- Shared package fetch_pkg:
  - state enum {FQ_IDLE, FQ_RUN};
  - PC_INCREMENT = 4;
  - clog2-derived widths for queue pointers/count and inflight counter.
- One sub-module, fetch_queue: circular buffer with 1 write port, ISSUE_WIDTH read lanes, variable pop count and flush.
- The top level holds the FSM, PC counters, credit and drop logic.

Test Plan:
1. Reset, then start with program_address = 0x00100, mem_req_ready = 1, 1-cycle response latency, out_ready = 1:
   - requests to word addresses 0x40, 0x41, 0x42 …;
   - lanes deliver PCs 0x100/0x104, 0x108/0x10C in order.
2. out_ready = 0 with QUEUE_DEPTH = 8:
   - exactly 8 responses are accepted and mem_req_valid drops;
   - count + inflight never exceeds 8;
   - raising out_ready drains 2 per cycle.
3. 3-cycle memory latency, 3 in flight, redirect to 0x00200:
   - next 3 responses discarded and queue empty;
   - first delivered PC is 0x200 with its correct data.
4. Second redirect to 0x00300 while drop_count = 2 and a response arrives the same cycle:
   - only stale responses are dropped;
   - first delivered PC is 0x300.
5. mem_req_ready toggling 1, 0, 0, 1: mem_req_addr is held stable during the stall, and no PC is skipped or duplicated.
6. Reset asserted mid-stream with 4 in flight: all outputs 0 next cycle, state IDLE, a late response is ignored, and restart from 0x000 is clean.

Source files
------------

// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and sizing helpers for the fetch front end.
package fetch_pkg;

  typedef enum logic {
    FQ_IDLE = 1'b0,
    FQ_RUN  = 1'b1
  } fq_state_e;

  localparam int PC_INCREMENT = 4;

  // Pointer width for a power-of-2 ring; a 1-entry ring still needs one bit.
  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must hold the value max_val itself.
  function automatic int cnt_bits(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_unit_queue.sv
// Circular instruction buffer: one write port, LANES in-order read lanes,
// variable pop count and single-cycle flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LANES   = 2,
  parameter int ENTRY_W = 52,
  localparam int PTR_W  = ptr_bits(DEPTH),
  localparam int CNT_W  = cnt_bits(DEPTH)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             push,
  input  logic [ENTRY_W-1:0]               push_data,
  input  logic [CNT_W-1:0]                 pop_cnt,
  output logic [CNT_W-1:0]                 count,
  output logic [LANES-1:0]                 lane_valid,
  output logic [LANES-1:0][ENTRY_W-1:0]    lane_data
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = count_q + CNT_W'(push) - pop_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; lanes are masked by count so stale slots never leak.
  always_ff @(posedge clock) begin
    if (push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PTR_W-1:0] idx;
    assign idx           = rd_ptr_q + PTR_W'(i);
    assign lane_valid[i] = count_q > CNT_W'(i);
    assign lane_data[i]  = lane_valid[i] ? mem_q[idx] : '0;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch front end: credit-limited pipelined requests, in-order
// response buffering, redirect flush with stale-response dropping.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int QUEUE_DEPTH     = 8,
  parameter int ISSUE_WIDTH     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [ADDRESS_BITS-1:0]             program_address,
  input  logic                                redirect,
  input  logic [ADDRESS_BITS-1:0]             redirect_target,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [ADDRESS_BITS-1:0]             mem_req_addr,
  input  logic                                mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]               mem_rsp_data,
  output logic [ISSUE_WIDTH-1:0]              out_valid,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]   out_inst,
  output logic [ISSUE_WIDTH*ADDRESS_BITS-1:0] out_pc,
  input  logic                                out_ready,
  input  logic                                report
);

  localparam int CNT_W   = cnt_bits(QUEUE_DEPTH);
  localparam int IF_W    = cnt_bits(MAX_OUTSTANDING);
  localparam int ENTRY_W = DATA_WIDTH + ADDRESS_BITS;
  localparam int unsigned QD_U = QUEUE_DEPTH;

  fq_state_e                 state_q, state_d;
  logic [ADDRESS_BITS-1:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [IF_W-1:0]           inflight_q, inflight_d, drop_q, drop_d;
  logic [ADDRESS_BITS-1:0]   target_raw, target;
  logic [CNT_W-1:0]          q_count, pop_cnt;
  logic                      flush, push, req_fire, rsp_take;
  int unsigned               credit_used;
  logic [ISSUE_WIDTH-1:0]              lane_valid;
  logic [ISSUE_WIDTH-1:0][ENTRY_W-1:0] lane_data;

  assign target_raw = start ? program_address : redirect_target;
  assign target     = target_raw & ~(ADDRESS_BITS'(3));

  // Start while running behaves exactly like a redirect to program_address.
  assign flush       = (state_q == FQ_RUN) && (start || redirect);
  assign credit_used = (QD_U + 32'(q_count) + 32'(inflight_q)) - QD_U;

  // Credit counts in-flight requests as occupied slots so a response always fits.
  assign mem_req_valid = (state_q == FQ_RUN) && !start && !redirect &&
                         (credit_used < QD_U) &&
                         (inflight_q < IF_W'(MAX_OUTSTANDING));
  assign mem_req_addr  = fetch_pc_q >> 2;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_take      = mem_rsp_valid && (inflight_q != '0);
  assign push          = rsp_take && (drop_q == '0) && !flush;

  always_comb begin
    pop_cnt = '0;
    if (out_ready && !flush)
      pop_cnt = (q_count > CNT_W'(ISSUE_WIDTH)) ? CNT_W'(ISSUE_WIDTH) : q_count;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + IF_W'(req_fire) - IF_W'(rsp_take);
    drop_d     = drop_q;
    case (state_q)
      FQ_IDLE: begin
        if (start) begin
          state_d    = FQ_RUN;
          fetch_pc_d = target;
          rsp_pc_d   = target;
        end
      end
      FQ_RUN: begin
        if (flush) begin
          fetch_pc_d = target;
          rsp_pc_d   = target;
          // Everything still owed by memory, minus this cycle's arrival, is stale.
          drop_d     = inflight_q - IF_W'(rsp_take);
        end else begin
          if (req_fire) fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(PC_INCREMENT);
          if (push)     rsp_pc_d   = rsp_pc_q + ADDRESS_BITS'(PC_INCREMENT);
          if (rsp_take && (drop_q != '0)) drop_d = drop_q - IF_W'(1);
        end
      end
      default: state_d = FQ_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FQ_IDLE;
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .LANES   (ISSUE_WIDTH),
    .ENTRY_W (ENTRY_W)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_data  ({mem_rsp_data, rsp_pc_q}),
    .pop_cnt    (pop_cnt),
    .count      (q_count),
    .lane_valid (lane_valid),
    .lane_data  (lane_data)
  );

  assign out_valid = lane_valid;
  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_out
    assign out_inst[i*DATA_WIDTH +: DATA_WIDTH]     = lane_data[i][ENTRY_W-1 -: DATA_WIDTH];
    assign out_pc[i*ADDRESS_BITS +: ADDRESS_BITS]   = lane_data[i][ADDRESS_BITS-1:0];
  end

`ifndef SYNTHESIS
  logic [31:0] cycle_q;
  always_ff @(posedge clock) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
    if (!reset && mem_rsp_valid && (inflight_q == '0))
      $error("fetch_queue_unit%0d: response with nothing in flight", CORE);
    if (report)
      $display("fq%0d cyc=%0d st=%0d fetch_pc=%h cnt=%0d infl=%0d drop=%0d lanes=%b pcs=%h",
               CORE, cycle_q, state_q, fetch_pc_q, q_count, inflight_q, drop_q,
               out_valid, out_pc);
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: latency-configurable memory model, credit and
// ordering scoreboard, per-cycle vector table plus redirect/stall/reset sequences.
module tb_fetch_queue_unit;
  localparam int DW = 32, AB = 20, QD = 8, IW = 2, MO = 4;

  logic clock = 1'b0;
  logic reset, start, redirect, mem_req_ready, mem_rsp_valid, out_ready, report;
  logic [AB-1:0] program_address, redirect_target, mem_req_addr;
  logic mem_req_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [IW-1:0] out_valid;
  logic [IW*DW-1:0] out_inst;
  logic [IW*AB-1:0] out_pc;

  always #5 clock = ~clock;

  fetch_queue_unit #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .QUEUE_DEPTH(QD),
                     .ISSUE_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
    .clock(clock), .reset(reset), .start(start), .program_address(program_address),
    .redirect(redirect), .redirect_target(redirect_target),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .report(report));

  typedef struct { logic [AB-1:0] addr; int gen; int due; } req_t;
  typedef struct { logic [AB-1:0] pc; logic [DW-1:0] inst; } exp_t;
  typedef struct { logic st; logic ordy; logic rv; logic [AB-1:0] addr;
                   logic [IW-1:0] ov; logic [AB-1:0] pc0; logic [AB-1:0] pc1; } vec_t;

  req_t pend[$];
  exp_t exp_q[$];
  req_t pres;
  bit   pres_v, running, chk_first, stalled;
  int   gen, outstanding, lat, cyc, n_cmp, n_err;
  logic [AB-1:0] first_pc, exp_req, stall_addr;
  // Pre-edge captures used by the post-edge model update.
  bit   c_rst, c_start_idle, c_flush, c_fire;
  logic [AB-1:0] c_tgt, c_addr;
  vec_t vt[8];

  function automatic logic [DW-1:0] mdata(input logic [AB-1:0] a);
    return {12'hA50, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe();
    int sz, np;
    logic exp_rv;
    logic [IW-1:0] mask;
    exp_t e;
    sz      = exp_q.size();
    c_rst   = reset;
    c_flush = running && (start || redirect);
    c_start_idle = start && !running;
    c_tgt   = (start ? program_address : redirect_target) & ~(AB'(3));
    c_fire  = mem_req_valid && mem_req_ready;
    c_addr  = mem_req_addr;
    if (!reset) begin
      exp_rv = running && !start && !redirect && (sz + outstanding < QD) && (outstanding < MO);
      chk("req_valid", mem_req_valid, exp_rv);
      for (int i = 0; i < IW; i++) mask[i] = (sz > i);
      chk("out_valid", out_valid, mask);
      if (stalled && !c_flush) begin
        chk("stall_valid", mem_req_valid, 1'b1);
        chk("stall_addr", mem_req_addr, stall_addr);
      end
      if (c_fire) chk("req_addr", mem_req_addr, exp_req);
      stalled = mem_req_valid && !mem_req_ready;
      stall_addr = mem_req_addr;
      if (out_ready && !c_flush) begin
        np = (sz < IW) ? sz : IW;
        for (int i = 0; i < np; i++) begin
          e = exp_q.pop_front();
          chk("lane_pc", out_pc[i*AB +: AB], e.pc);
          chk("lane_inst", out_inst[i*DW +: DW], e.inst);
          if (i == 0 && chk_first) begin
            chk("first_pc", out_pc[AB-1:0], first_pc);
            chk_first = 0;
          end
        end
      end
    end
  endtask

  task automatic update();
    req_t r;
    logic [AB-1:0] pcv;
    cyc++;
    if (c_rst) begin
      pend.delete(); exp_q.delete();
      outstanding = 0; running = 0; pres_v = 0; stalled = 0;
    end else begin
      if (pres_v) begin
        outstanding--;
        if (!c_flush && pres.gen == gen) begin
          pcv = pres.addr << 2;
          exp_q.push_back('{pcv, mdata(pres.addr)});
        end
      end
      pres_v = 0;
      if (c_flush || c_start_idle) begin
        gen++; exp_q.delete(); exp_req = c_tgt >> 2; running = 1; stalled = 0;
      end
      if (c_fire) begin
        r.addr = c_addr; r.gen = gen; r.due = cyc + lat - 1;
        pend.push_back(r);
        outstanding++; exp_req++;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        pres = pend.pop_front(); pres_v = 1;
      end
    end
    mem_rsp_valid = pres_v;
    mem_rsp_data  = pres_v ? mdata(pres.addr) : '0;
  endtask

  task automatic tick();
    #1;
    observe();
    @(posedge clock);
    #1;
    update();
  endtask

  task automatic do_reset();
    reset = 1; start = 0; redirect = 0; out_ready = 0; mem_req_ready = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic wait_first(input string name);
    for (int k = 0; k < 40 && chk_first; k++) tick();
    if (chk_first) begin
      n_cmp++; n_err++; chk_first = 0;
      $display("FAIL %s: no delivery within bound", name);
    end
  endtask

  task automatic wait_outstanding(input int n, input string name);
    for (int k = 0; k < 30 && outstanding < n; k++) tick();
    if (outstanding < n) begin
      n_cmp++; n_err++;
      $display("FAIL %s: in-flight count %0d never reached %0d", name, outstanding, n);
    end
  endtask

  initial begin
    reset = 1; start = 0; redirect = 0; mem_req_ready = 1; out_ready = 0; report = 0;
    program_address = '0; redirect_target = '0; mem_rsp_valid = 0; mem_rsp_data = '0;
    lat = 1; cyc = 0; gen = 0; outstanding = 0; n_cmp = 0; n_err = 0;
    pres_v = 0; running = 0; chk_first = 0; stalled = 0; exp_req = '0;

    // Per-cycle vectors for the first start: {start, out_ready, req_valid, req_addr, out_valid, pc0, pc1}
    vt[0] = '{1'b1, 1'b0, 1'b0, 20'h00000, 2'b00, 20'h0,   20'h0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 20'h00040, 2'b00, 20'h0,   20'h0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 20'h00041, 2'b00, 20'h0,   20'h0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 20'h00042, 2'b01, 20'h100, 20'h0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 20'h00043, 2'b11, 20'h100, 20'h104};
    vt[5] = '{1'b0, 1'b1, 1'b1, 20'h00044, 2'b01, 20'h108, 20'h0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 20'h00045, 2'b01, 20'h10C, 20'h0};
    vt[7] = '{1'b0, 1'b1, 1'b1, 20'h00046, 2'b11, 20'h10C, 20'h110};

    do_reset();
    #1;
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_req_addr", mem_req_addr, 20'h0);
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_out_pc", out_pc, '0);

    // Test 1: boot at 0x100, 1-cycle memory
    program_address = 20'h00100; lat = 1;
    for (int r = 0; r < 8; r++) begin
      start = vt[r].st; out_ready = vt[r].ordy;
      #1;
      chk("t1_req_valid", mem_req_valid, vt[r].rv);
      if (vt[r].rv) chk("t1_req_addr", mem_req_addr, vt[r].addr);
      chk("t1_out_valid", out_valid, vt[r].ov);
      if (vt[r].ov[0]) chk("t1_pc0", out_pc[AB-1:0], vt[r].pc0);
      if (vt[r].ov[1]) chk("t1_pc1", out_pc[2*AB-1:AB], vt[r].pc1);
      tick();
    end
    repeat (6) tick();

    // Test 2: decode stalled until the queue fills, then drain
    do_reset();
    program_address = 20'h00100; lat = 1; start = 1; tick(); start = 0;
    repeat (14) tick();
    #1;
    chk("t2_full_req_valid", mem_req_valid, 1'b0);
    chk("t2_full_lanes", out_valid, 2'b11);
    chk("t2_full_pc1", out_pc[2*AB-1:AB], 20'h104);
    out_ready = 1;
    tick();
    #1;
    chk("t2_drain_pc0", out_pc[AB-1:0], 20'h108);
    repeat (10) tick();

    // Test 3: 3-cycle memory, redirect with 3 in flight
    do_reset();
    program_address = 20'h00000; lat = 3; out_ready = 1; start = 1; tick(); start = 0;
    wait_outstanding(3, "t3_fill");
    redirect = 1; redirect_target = 20'h00200; first_pc = 20'h00200; chk_first = 1;
    tick();
    redirect = 0;
    #1;
    chk("t3_flushed", out_valid, 2'b00);
    wait_first("t3_first");

    // Test 4: back-to-back redirects, second one lands on a dropped response
    wait_outstanding(3, "t4_fill");
    redirect = 1; redirect_target = 20'h00280; tick();
    redirect_target = 20'h00301; first_pc = 20'h00300; chk_first = 1;
    tick();
    redirect = 0;
    wait_first("t4_first");
    repeat (6) tick();

    // Test 5: request stall pattern 1,0,0,1
    do_reset();
    program_address = 20'h00040; lat = 1; out_ready = 1; first_pc = 20'h00040; chk_first = 1;
    start = 1; tick(); start = 0;
    tick();
    mem_req_ready = 1; tick();
    mem_req_ready = 0; tick();
    mem_req_ready = 0; tick();
    mem_req_ready = 1; tick();
    wait_first("t5_first");
    repeat (8) tick();

    // Test 6: reset with 4 in flight, late response in the reset cycle
    do_reset();
    program_address = 20'h00000; lat = 4; out_ready = 1; start = 1; tick(); start = 0;
    wait_outstanding(4, "t6_fill");
    reset = 1; tick(); reset = 0;
    #1;
    chk("t6_req_valid", mem_req_valid, 1'b0);
    chk("t6_req_addr", mem_req_addr, 20'h0);
    chk("t6_out_valid", out_valid, 2'b00);
    chk("t6_out_inst", out_inst, '0);
    chk("t6_out_pc", out_pc, '0);
    lat = 1; first_pc = 20'h00000; chk_first = 1; start = 1; tick(); start = 0;
    wait_first("t6_restart");
    repeat (8) tick();

    report = 1; tick(); report = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
